key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter N_KEYS, default 3: number of independent push-button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: stability window, 10 ms at 100 MHz; legal range >= 2.
REQ-003 SHALL have parameter LONG_PRESS_CYCLES, default 100_000_000: long-press threshold, 1 s; SHALL be > DEBOUNCE_CYCLES.
REQ-004 SHALL have port clk100_i  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rstn_i  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port key_i  input  N_KEYS  raw board buttons, active-low (0 = pressed), asynchronous to clk100_i.
REQ-007 SHALL have port key_level_o  output  N_KEYS  debounced state, active-high (1 = pressed).
REQ-008 SHALL have port key_press_o  output  N_KEYS  one-cycle pulse on debounced press.
REQ-009 SHALL have port key_release_o  output  N_KEYS  one-cycle pulse on debounced release.
REQ-010 SHALL have port key_long_o  output  N_KEYS  one-cycle pulse when a press reaches LONG_PRESS_CYCLES.

Function
REQ-011 Each channel SHALL be fully independent; events on one channel SHALL never affect another.
REQ-012 Each key_i bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Each channel SHALL invert the synchronized value to an active-high sample (1 = pressed).
REQ-014 Each channel SHALL hold a debounce counter of $clog2(DEBOUNCE_CYCLES)+1 bits.
REQ-015 The debounce counter SHALL clear to 0 in any cycle where the sample equals key_level_o.
REQ-016 The debounce counter SHALL increment in any cycle where the sample differs from key_level_o.
REQ-017 On the edge where the counter would reach DEBOUNCE_CYCLES, key_level_o SHALL toggle and the counter SHALL clear.
REQ-018 Latency: a raw change stable from edge k SHALL update key_level_o at edge k+1+DEBOUNCE_CYCLES (sync delay plus window).
REQ-019 A bounce or glitch shorter than DEBOUNCE_CYCLES sampled cycles SHALL produce no change on any output.
REQ-020 key_press_o SHALL be 1 for exactly the cycle in which key_level_o is first 1 after a 0->1 toggle.
REQ-021 key_release_o SHALL be 1 for exactly the cycle in which key_level_o is first 0 after a 1->0 toggle.
REQ-022 All outputs SHALL be registered, with no combinational path from key_i.
REQ-023 Each channel SHALL implement per-key FSM state RELEASED (level 0, hold counter cleared).
REQ-024 Each channel SHALL implement per-key FSM state HELD (level 1, hold counter incrementing each cycle).
REQ-025 Each channel SHALL implement per-key FSM state LONG (level 1, hold counter frozen).
REQ-026 Transition RELEASED->HELD SHALL occur on the press toggle, together with key_press_o.
REQ-027 Transition HELD->LONG SHALL occur when the hold counter reaches LONG_PRESS_CYCLES-1, with key_long_o pulsed that cycle.
REQ-028 Transition HELD->RELEASED and LONG->RELEASED SHALL occur on the release toggle, together with key_release_o.
REQ-029 key_long_o SHALL fire at most once per press; the hold counter SHALL saturate and never wrap.
REQ-030 A release before the threshold SHALL give no key_long_o; the hold counter SHALL clear on release.
REQ-031 key_press_o, key_release_o and key_long_o SHALL never be asserted together on one channel.
REQ-032 Simultaneous events on several channels in one cycle SHALL all be reported in that cycle.

Reset
REQ-033 While rstn_i=0 the synchronizer flops SHALL be 1 (released) and the debounce and hold counters SHALL be 0.
REQ-034 While rstn_i=0 the FSMs SHALL be in RELEASED and every output SHALL be 0.
REQ-035 On rstn_i deassert with a key held, the key SHALL be detected as a new press after 2+DEBOUNCE_CYCLES cycles with key_press_o pulsed.
REQ-036 Reset asserted mid-press SHALL produce no key_release_o pulse.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, N_KEYS=3)
REQ-037 Clean press: key_i[0] 1->0 and held -> key_level_o[0]=1 exactly 5 edges later; key_press_o[0]=1 for 1 cycle.
REQ-038 Bounce: key_i[1] pressed 3 cycles, released 1, then held -> no pulse during bounce; key_press_o[1] fires once, 5 edges after the final stable press.
REQ-039 Long press: key_i[2] held 40 cycles -> key_long_o[2] fires once, 20 cycles after key_press_o[2]; on release key_release_o[2] fires once.
REQ-040 Short press: held 10 cycles then released -> key_press_o and key_release_o fire, key_long_o stays 0.
REQ-041 Simultaneous: key_i[0] and key_i[2] pressed on the same edge -> key_press_o=3'b101 in one cycle.
REQ-042 Reset mid-hold: rstn_i pulsed low with key_i[0] held -> outputs 0 with no release pulse; key_press_o[0] fires 6 cycles after deassert.

Source files
------------

// File: rtl/key_conditioner.sv
// Per-channel push-button conditioner: 2-flop synchronizer, debounce filter,
// press/release edge pulses and a long-press detector, one FSM per key.
module key_conditioner #(
  parameter int N_KEYS            = 3,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000
) (
  input  logic              clk100_i,
  input  logic              rstn_i,
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] key_level_o,
  output logic [N_KEYS-1:0] key_press_o,
  output logic [N_KEYS-1:0] key_release_o,
  output logic [N_KEYS-1:0] key_long_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONG     = 2'd2
  } key_state_e;

  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q, long_d;
  logic [DB_W-1:0]   db_cnt_q   [N_KEYS];
  logic [DB_W-1:0]   db_cnt_d   [N_KEYS];
  logic [HOLD_W-1:0] hold_cnt_q [N_KEYS];
  logic [HOLD_W-1:0] hold_cnt_d [N_KEYS];
  key_state_e        state_q    [N_KEYS];
  key_state_e        state_d    [N_KEYS];

  logic [N_KEYS-1:0] sample;
  logic [N_KEYS-1:0] toggle;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    sync1_d   = key_i;
    sync2_d   = sync1_q;
    sample    = ~sync2_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    toggle    = '0;

    for (int i = 0; i < N_KEYS; i++) begin
      db_cnt_d[i]   = '0;
      hold_cnt_d[i] = hold_cnt_q[i];
      state_d[i]    = state_q[i];

      // The counter only runs while the sample disagrees with the level;
      // any agreeing cycle restarts the stability window.
      if (sample[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
          toggle[i]  = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end

      case (state_q[i])
        ST_RELEASED: begin
          hold_cnt_d[i] = '0;
          if (toggle[i]) begin
            state_d[i] = ST_HELD;
            press_d[i] = 1'b1;
          end
        end
        ST_HELD: begin
          // Release wins over the threshold so pulses stay mutually exclusive.
          if (toggle[i]) begin
            state_d[i]    = ST_RELEASED;
            release_d[i]  = 1'b1;
            hold_cnt_d[i] = '0;
          end else if (hold_cnt_q[i] == HOLD_LAST) begin
            state_d[i] = ST_LONG;
            long_d[i]  = 1'b1;
          end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (toggle[i]) begin
            state_d[i]    = ST_RELEASED;
            release_d[i]  = 1'b1;
            hold_cnt_d[i] = '0;
          end
        end
        default: begin
          state_d[i]    = ST_RELEASED;
          hold_cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: synchronizer resets to 1 because the raw buttons are active-low.
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
        state_q[i]    <= ST_RELEASED;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        state_q[i]    <= state_d[i];
      end
    end
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_long_o    = long_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
module tb_key_conditioner;

  localparam int N_KEYS = 3;
  localparam int DB     = 4;
  localparam int LP     = 20;

  logic              clk100_i;
  logic              rstn_i;
  logic [N_KEYS-1:0] key_i;
  logic [N_KEYS-1:0] key_level_o;
  logic [N_KEYS-1:0] key_press_o;
  logic [N_KEYS-1:0] key_release_o;
  logic [N_KEYS-1:0] key_long_o;

  int passed;
  int total;

  key_conditioner #(
    .N_KEYS(N_KEYS),
    .DEBOUNCE_CYCLES(DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk100_i(clk100_i),
    .rstn_i(rstn_i),
    .key_i(key_i),
    .key_level_o(key_level_o),
    .key_press_o(key_press_o),
    .key_release_o(key_release_o),
    .key_long_o(key_long_o)
  );

  initial clk100_i = 1'b0;
  always #5 clk100_i = ~clk100_i;

  // Advance one rising edge and settle 1 ns past it; stimulus and sampling
  // both happen here, away from the edge.
  task automatic tick();
    @(posedge clk100_i);
    #1;
  endtask

  // {level, press, release, long}
  function automatic logic [4*N_KEYS-1:0] observed();
    return {key_level_o, key_press_o, key_release_o, key_long_o};
  endfunction

  task automatic test_reset();
    logic [4*N_KEYS-1:0] obs;
    rstn_i = 1'b0;
    key_i  = 3'b111;
    #3;
    for (int i = 1; i <= 3; i++) begin
      tick();
      obs = observed();
      total++;
      if (obs !== '0) $display("FAIL reset_hold[%0d]: got %h want 000", i, obs);
      else passed++;
    end
    rstn_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      obs = observed();
      total++;
      if (obs !== '0) $display("FAIL reset_idle[%0d]: got %h want 000", i, obs);
      else passed++;
    end
  endtask

  // Key 0 pressed cleanly, then released; level appears at the 6th edge after
  // the drive (first sampling edge + 1 sync + 4 debounce).
  task automatic test_clean_press();
    logic [4*N_KEYS-1:0] obs, exp;
    key_i = 3'b110;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i >= 6) ? 3'b001 : 3'b000, (i == 6) ? 3'b001 : 3'b000, 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL clean_press[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
    key_i = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i < 6) ? 3'b001 : 3'b000, 3'b000, (i == 6) ? 3'b001 : 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL clean_release[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
  endtask

  // Key 1: low 3 samples, high 1, then low for good. The bounce builds the
  // counter to DB-1 only, so the press lands 5 edges after the final low is
  // first sampled (drive step 5 -> edge step 10).
  task automatic test_bounce();
    logic [4*N_KEYS-1:0] obs, exp;
    for (int i = 1; i <= 12; i++) begin
      key_i = (i == 4) ? 3'b111 : 3'b101;
      tick();
      exp = {(i >= 10) ? 3'b010 : 3'b000, (i == 10) ? 3'b010 : 3'b000, 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL bounce[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
    key_i = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i < 6) ? 3'b010 : 3'b000, 3'b000, (i == 6) ? 3'b010 : 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL bounce_release[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
  endtask

  // Key 2 held 40 cycles: press at 6, long exactly 20 edges later, once only.
  task automatic test_long_press();
    logic [4*N_KEYS-1:0] obs, exp;
    key_i = 3'b011;
    for (int i = 1; i <= 40; i++) begin
      tick();
      exp = {(i >= 6) ? 3'b100 : 3'b000, (i == 6) ? 3'b100 : 3'b000, 3'b000,
             (i == 26) ? 3'b100 : 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL long_press[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
    key_i = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i < 6) ? 3'b100 : 3'b000, 3'b000, (i == 6) ? 3'b100 : 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL long_release[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
  endtask

  // Key 0 held 10 cycles: press and release, no long pulse.
  task automatic test_short_press();
    logic [4*N_KEYS-1:0] obs, exp;
    key_i = 3'b110;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp = {(i >= 6 && i < 16) ? 3'b001 : 3'b000, (i == 6) ? 3'b001 : 3'b000,
             (i == 16) ? 3'b001 : 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL short_press[%0d]: got %h want %h", i, obs, exp);
      else passed++;
      if (i == 10) key_i = 3'b111;
    end
  endtask

  task automatic test_simultaneous();
    logic [4*N_KEYS-1:0] obs, exp;
    key_i = 3'b010;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i >= 6) ? 3'b101 : 3'b000, (i == 6) ? 3'b101 : 3'b000, 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL simul_press[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
    key_i = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i < 6) ? 3'b101 : 3'b000, 3'b000, (i == 6) ? 3'b101 : 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL simul_release[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
  endtask

  // Reset pulsed while key 0 is held: no release pulse, then a fresh press
  // 6 edges after deassert.
  task automatic test_reset_mid_hold();
    logic [4*N_KEYS-1:0] obs, exp;
    key_i = 3'b110;
    for (int i = 1; i <= 8; i++) tick();
    obs = observed();
    exp = {3'b001, 3'b000, 3'b000, 3'b000};
    total++;
    if (obs !== exp) $display("FAIL mid_hold_pre[%0d]: got %h want %h", 8, obs, exp);
    else passed++;
    #2;
    rstn_i = 1'b0;
    #1;
    obs = observed();
    total++;
    if (obs !== '0) $display("FAIL mid_hold_async: got %h want 000", obs);
    else passed++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      obs = observed();
      total++;
      if (obs !== '0) $display("FAIL mid_hold_in_reset[%0d]: got %h want 000", i, obs);
      else passed++;
    end
    rstn_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i >= 6) ? 3'b001 : 3'b000, (i == 6) ? 3'b001 : 3'b000, 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL mid_hold_repress[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
    key_i = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i < 6) ? 3'b001 : 3'b000, 3'b000, (i == 6) ? 3'b001 : 3'b000, 3'b000};
      obs = observed();
      total++;
      if (obs !== exp) $display("FAIL mid_hold_release[%0d]: got %h want %h", i, obs, exp);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_short_press();
    test_simultaneous();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
